// File: rtl/grn_seq.sv
// -----------------------------------------------------------------------------
// grn_seq -- pseudo-random symbol sequence generator for the Genius game core.
//
// A Galois LFSR produces symbols (button/colour indices). Each accepted append
// stores the low SYM_WIDTH bits of the current LFSR value into the sequence
// memory and steps the LFSR. The stored sequence is replayed from index 0 for
// LED display and for checking player input. Free-running mode steps the LFSR
// every cycle so that player timing stirs the entropy.
//
// Ports:
//   i_clk        clock, all logic on the rising edge
//   i_rst        synchronous reset, active-high, overrides every other input
//   i_seed_we    load i_seed into the LFSR (a zero seed loads 1 instead)
//   i_seed       seed value
//   i_free_run   step the LFSR every cycle while high
//   i_append     generate and store one symbol (IDLE only)
//   i_clear      empty the sequence and abort playback
//   i_rd_start   begin playback at index 0 (restarts if already playing)
//   i_rd_next    advance the playback pointer
//   o_rd_data    current playback symbol (registered)
//   o_rd_valid   o_rd_data is valid
//   o_rd_last    o_rd_valid and the pointer is at the final entry
//   o_len        stored sequence length
//   o_full       o_len == DEPTH
//   o_overflow   one-cycle pulse: an append was rejected because full
//
// Input priority at one edge: rst > clear > seed_we > append/step.
// -----------------------------------------------------------------------------
module grn_seq #(
   parameter int                    LFSR_WIDTH = 16,
   parameter int                    SYM_WIDTH  = 2,
   parameter int                    DEPTH      = 32,
   parameter logic [LFSR_WIDTH-1:0] TAPS       = 16'hB400,
   parameter logic [LFSR_WIDTH-1:0] RESET_SEED = {{(LFSR_WIDTH-1){1'b0}}, 1'b1}
) (
   input  logic                         i_clk,
   input  logic                         i_rst,
   input  logic                         i_seed_we,
   input  logic [LFSR_WIDTH-1:0]        i_seed,
   input  logic                         i_free_run,
   input  logic                         i_append,
   input  logic                         i_clear,
   input  logic                         i_rd_start,
   input  logic                         i_rd_next,
   output logic [SYM_WIDTH-1:0]         o_rd_data,
   output logic                         o_rd_valid,
   output logic                         o_rd_last,
   output logic [$clog2(DEPTH+1)-1:0]   o_len,
   output logic                         o_full,
   output logic                         o_overflow
);

   localparam int LEN_W  = $clog2(DEPTH+1);
   localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_PLAY = 1'b1
   } state_t;

   // ---------------------------------------------------------------------------
   // Declarations
   // ---------------------------------------------------------------------------
   state_t                  r_state;
   state_t                  w_state_nxt;
   logic [ADDR_W-1:0]       r_ptr;
   logic [ADDR_W-1:0]       w_ptr_nxt;

   logic [LFSR_WIDTH-1:0]   r_lfsr;
   logic [LFSR_WIDTH-1:0]   w_lfsr_step;
   logic [LFSR_WIDTH-1:0]   w_lfsr_nxt;

   logic [LEN_W-1:0]        r_len;
   logic [LEN_W-1:0]        w_len_nxt;

   logic [SYM_WIDTH-1:0]    r_mem [DEPTH];

   logic [SYM_WIDTH-1:0]    r_rd_data;
   logic                    r_rd_valid;
   logic                    r_rd_last;
   logic                    r_overflow;

   logic                    w_idle;
   logic                    w_full;
   logic                    w_append_req;
   logic                    w_append_ok;
   logic                    w_append_full;
   logic                    w_ptr_at_end;
   logic                    w_rd_valid_nxt;
   logic                    w_rd_last_nxt;

   // ---------------------------------------------------------------------------
   // Datapath decode
   // ---------------------------------------------------------------------------
   always_comb begin : lfsr_step_c
      w_lfsr_step = (r_lfsr >> 1) ^ (r_lfsr[0] ? TAPS : '0);
   end

   always_comb begin : ctrl_decode_c
      // NOTE: every combinational output gets a default before any branch, so
      // no path leaves a signal unassigned and no latch is inferred.
      w_idle        = (r_state == ST_IDLE);
      w_full        = (r_len == LEN_W'(DEPTH));
      // An append only counts when nothing of higher priority claims the edge
      // and the sequence is not frozen for playback.
      w_append_req  = i_append & ~i_rst & ~i_clear & ~i_seed_we & w_idle;
      w_append_ok   = w_append_req & ~w_full;
      w_append_full = w_append_req & w_full;

      w_len_nxt = r_len;
      if (i_clear) begin
         w_len_nxt = '0;
      end else if (w_append_ok) begin
         w_len_nxt = r_len + LEN_W'(1);
      end

      // Append and free_run together still give a single step.
      w_lfsr_nxt = r_lfsr;
      if (i_clear) begin
         if (i_free_run) begin
            w_lfsr_nxt = w_lfsr_step;
         end
      end else if (i_seed_we) begin
         // An all-zero state would lock the LFSR up forever.
         w_lfsr_nxt = (i_seed == '0) ? LFSR_WIDTH'(1) : i_seed;
      end else if (i_free_run || w_append_ok) begin
         w_lfsr_nxt = w_lfsr_step;
      end
   end

   // ---------------------------------------------------------------------------
   // Playback FSM: state register
   // ---------------------------------------------------------------------------
   always_ff @(posedge i_clk) begin : fsm_state_r
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      if (i_rst) begin
         r_state <= ST_IDLE;
         r_ptr   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_ptr   <= w_ptr_nxt;
      end
   end

   // ---------------------------------------------------------------------------
   // Playback FSM: next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin : fsm_next_c
      // len is frozen during PLAY, so the end test can use the stored length.
      w_ptr_at_end = (LEN_W'(r_ptr) == (r_len - LEN_W'(1)));
      w_state_nxt  = r_state;
      w_ptr_nxt    = r_ptr;

      if (i_clear) begin
         w_state_nxt = ST_IDLE;
         w_ptr_nxt   = '0;
      end else begin
         unique case (r_state)
            ST_IDLE: begin
               if (i_rd_start && (r_len != '0)) begin
                  w_state_nxt = ST_PLAY;
                  w_ptr_nxt   = '0;
               end
            end
            ST_PLAY: begin
               if (i_rd_start) begin
                  w_ptr_nxt = '0;
               end else if (i_rd_next) begin
                  if (w_ptr_at_end) begin
                     w_state_nxt = ST_IDLE;
                  end else begin
                     w_ptr_nxt = r_ptr + ADDR_W'(1);
                  end
               end
            end
            default: begin
               w_state_nxt = ST_IDLE;
               w_ptr_nxt   = '0;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Playback FSM: output logic
   // ---------------------------------------------------------------------------
   always_comb begin : fsm_out_c
      // Playback flags are registered, so they are computed from the next state
      // to line up with the symbol fetched from mem[w_ptr_nxt]. A start in IDLE
      // can coincide with an accepted append, hence the next length is used.
      w_rd_valid_nxt = (w_state_nxt == ST_PLAY);
      w_rd_last_nxt  = w_rd_valid_nxt &&
                       (LEN_W'(w_ptr_nxt) == (w_len_nxt - LEN_W'(1)));

      o_rd_data  = r_rd_data;
      o_rd_valid = r_rd_valid;
      o_rd_last  = r_rd_last;
      o_len      = r_len;
      o_full     = w_full;
      o_overflow = r_overflow;
   end

   // ---------------------------------------------------------------------------
   // Registered datapath
   // ---------------------------------------------------------------------------
   always_ff @(posedge i_clk) begin : datapath_r
      if (i_rst) begin
         r_lfsr     <= RESET_SEED;
         r_len      <= '0;
         r_rd_data  <= '0;
         r_rd_valid <= 1'b0;
         r_rd_last  <= 1'b0;
         r_overflow <= 1'b0;
      end else begin
         r_lfsr     <= w_lfsr_nxt;
         r_len      <= w_len_nxt;
         r_rd_valid <= w_rd_valid_nxt;
         r_rd_last  <= w_rd_last_nxt;
         r_overflow <= w_append_full;
         // The read index is always below the old length, so it never hits the
         // entry being written on the same edge.
         if (w_rd_valid_nxt) begin
            r_rd_data <= r_mem[w_ptr_nxt];
         end
      end
   end

   // NOTE: the sequence memory has no reset; entries at or above len are never
   // read, so clearing it would only cost a reset fan-out into the array.
   always_ff @(posedge i_clk) begin : seq_mem_r
      if (w_append_ok) begin
         r_mem[r_len[ADDR_W-1:0]] <= r_lfsr[SYM_WIDTH-1:0];
      end
   end

endmodule

// File: tb/tb_grn_seq.sv
// -----------------------------------------------------------------------------
// tb_grn_seq -- self-checking bench for grn_seq (DEPTH=4 so full/overflow are
// reached often). Directed scenarios are followed by randomized traffic, all
// compared every cycle against a queue-based reference model.
// -----------------------------------------------------------------------------
module tb_grn_seq;

   localparam int          LW    = 16;
   localparam int          SW    = 2;
   localparam int          DEPTH = 4;
   localparam int          LEN_W = $clog2(DEPTH+1);
   localparam logic [15:0] TAPS  = 16'hB400;

   logic             clk = 1'b0;
   logic             rst, seed_we, free_run, append, clear, rd_start, rd_next;
   logic [LW-1:0]    seed;
   logic [SW-1:0]    rd_data;
   logic             rd_valid, rd_last, full, overflow;
   logic [LEN_W-1:0] len;

   always #5 clk = ~clk;

   grn_seq #(
      .LFSR_WIDTH (LW),
      .SYM_WIDTH  (SW),
      .DEPTH      (DEPTH),
      .TAPS       (TAPS),
      .RESET_SEED (16'h0001)
   ) dut (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_seed_we  (seed_we),
      .i_seed     (seed),
      .i_free_run (free_run),
      .i_append   (append),
      .i_clear    (clear),
      .i_rd_start (rd_start),
      .i_rd_next  (rd_next),
      .o_rd_data  (rd_data),
      .o_rd_valid (rd_valid),
      .o_rd_last  (rd_last),
      .o_len      (len),
      .o_full     (full),
      .o_overflow (overflow)
   );

   int n_err = 0;
   int n_chk = 0;

   // Reference model: the sequence is a queue, playback is a flag and an index.
   logic [15:0] m_lfsr;
   int          m_seq[$];
   bit          m_play;
   int          m_idx;
   int          m_data;
   bit          m_valid, m_last, m_ovf;
   int          ovf_seen;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [15:0] galois(input logic [15:0] v);
      return (v >> 1) ^ (v[0] ? TAPS : 16'h0000);
   endfunction

   task automatic model_update();
      int sz0;
      bit acc;
      if (rst) begin
         m_lfsr = 16'h0001;
         m_seq.delete();
         m_play = 1'b0;
         m_idx  = 0;
         m_data = 0;
         m_ovf  = 1'b0;
      end else begin
         m_ovf = 1'b0;
         sz0   = m_seq.size();
         if (clear) begin
            m_seq.delete();
            m_play = 1'b0;
            if (free_run) m_lfsr = galois(m_lfsr);
         end else begin
            if (seed_we) begin
               m_lfsr = (seed == 16'h0000) ? 16'h0001 : seed;
            end else begin
               acc = append && !m_play && (sz0 < DEPTH);
               if (append && !m_play && (sz0 == DEPTH)) m_ovf = 1'b1;
               if (acc) m_seq.push_back(int'(m_lfsr[1:0]));
               if (acc || free_run) m_lfsr = galois(m_lfsr);
            end
            if (!m_play) begin
               if (rd_start && (sz0 > 0)) begin
                  m_play = 1'b1;
                  m_idx  = 0;
               end
            end else if (rd_start) begin
               m_idx = 0;
            end else if (rd_next) begin
               if (m_idx == m_seq.size() - 1) m_play = 1'b0;
               else                           m_idx++;
            end
         end
      end
      m_valid = m_play;
      if (m_play) m_data = m_seq[m_idx];
      m_last = m_play && (m_idx == m_seq.size() - 1);
   endtask

   task automatic compare_all();
      check("rd_valid", 32'(rd_valid), 32'(m_valid));
      check("rd_last",  32'(rd_last),  32'(m_last));
      check("len",      32'(len),      32'(m_seq.size()));
      check("full",     32'(full),     32'(m_seq.size() == DEPTH));
      check("overflow", 32'(overflow), 32'(m_ovf));
      check("lfsr",     32'(dut.r_lfsr), 32'(m_lfsr));
      if (m_valid) check("rd_data", 32'(rd_data), 32'(m_data));
   endtask

   // One clock: inputs are held across the edge, the model advances with the
   // same inputs, and outputs are sampled 1 time unit later.
   task automatic tick();
      @(posedge clk);
      model_update();
      #1;
      if (overflow) ovf_seen++;
      compare_all();
   endtask

   task automatic idle_inputs();
      rst = 0; seed_we = 0; seed = '0; free_run = 0;
      append = 0; clear = 0; rd_start = 0; rd_next = 0;
   endtask

   initial begin
      idle_inputs();
      m_lfsr = 16'h0001;
      m_play = 0; m_idx = 0; m_data = 0; m_valid = 0; m_last = 0; m_ovf = 0;
      ovf_seen = 0;

      // Scenario 1: reset, seed 1, three appends.
      rst = 1; tick(); rst = 0;
      check("reset_rd_data", 32'(rd_data), 32'h0);
      check("reset_lfsr", 32'(dut.r_lfsr), 32'h0001);
      seed_we = 1; seed = 16'h0001; tick(); seed_we = 0;
      append = 1; repeat (3) tick(); append = 0;
      check("s1_len", 32'(len), 32'd3);
      check("s1_lfsr", 32'(dut.r_lfsr), 32'h2D00);

      // Scenario 2: playback of 1,0,0 with rd_last on the third symbol.
      rd_start = 1; tick(); rd_start = 0;
      check("s2_d0", 32'(rd_data), 32'd1);
      check("s2_v0", 32'(rd_valid), 32'd1);
      check("s2_l0", 32'(rd_last), 32'd0);
      rd_next = 1; tick();
      check("s2_d1", 32'(rd_data), 32'd0);
      check("s2_l1", 32'(rd_last), 32'd0);
      tick();
      check("s2_d2", 32'(rd_data), 32'd0);
      check("s2_l2", 32'(rd_last), 32'd1);
      tick(); rd_next = 0;
      check("s2_done_valid", 32'(rd_valid), 32'd0);

      // Scenario 3: zero seed loads 1, then two free-running steps.
      seed_we = 1; seed = 16'h0000; tick(); seed_we = 0;
      check("s3_seed0", 32'(dut.r_lfsr), 32'h0001);
      free_run = 1; repeat (2) tick(); free_run = 0;
      check("s3_lfsr", 32'(dut.r_lfsr), 32'h5A00);
      check("s3_len", 32'(len), 32'd3);

      // Scenario 4: five appends into a depth-4 memory.
      rst = 1; tick(); rst = 0;
      ovf_seen = 0;
      append = 1; repeat (5) tick(); append = 0;
      tick();
      check("s4_len", 32'(len), 32'd4);
      check("s4_full", 32'(full), 32'd1);
      check("s4_ovf_count", 32'(ovf_seen), 32'd1);
      check("s4_lfsr", 32'(dut.r_lfsr), 32'h1680);

      // Scenario 5: append ignored in PLAY, clear aborts, start on empty.
      rd_start = 1; tick(); rd_start = 0;
      rd_next = 1; tick(); rd_next = 0;
      check("s5_d1", 32'(rd_data), 32'd0);
      append = 1; tick(); append = 0;
      check("s5_append_ign_len", 32'(len), 32'd4);
      check("s5_append_no_ovf", 32'(overflow), 32'd0);
      clear = 1; tick(); clear = 0;
      check("s5_clr_valid", 32'(rd_valid), 32'd0);
      check("s5_clr_len", 32'(len), 32'd0);
      rd_start = 1; tick(); rd_start = 0;
      check("s5_empty_start", 32'(rd_valid), 32'd0);

      // Scenario 6: reset mid-playback alongside append and seed_we.
      append = 1; repeat (2) tick(); append = 0;
      rd_start = 1; tick(); rd_start = 0;
      rd_next = 1; tick(); rd_next = 0;
      rst = 1; append = 1; seed_we = 1; seed = 16'hBEEF; free_run = 1;
      tick();
      idle_inputs();
      check("s6_valid", 32'(rd_valid), 32'd0);
      check("s6_last", 32'(rd_last), 32'd0);
      check("s6_len", 32'(len), 32'd0);
      check("s6_data", 32'(rd_data), 32'd0);
      check("s6_lfsr", 32'(dut.r_lfsr), 32'h0001);

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         rst      = ($urandom_range(0, 199) == 0);
         clear    = ($urandom_range(0, 24) == 0);
         seed_we  = ($urandom_range(0, 15) == 0);
         seed     = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
         free_run = ($urandom_range(0, 3) == 0);
         append   = ($urandom_range(0, 2) == 0);
         rd_start = ($urandom_range(0, 7) == 0);
         rd_next  = ($urandom_range(0, 1) == 0);
         tick();
      end
      idle_inputs();
      tick();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/grn_seq.md
Name: grn_seq

Overview:
Parametrised pseudo-random sequence generator for the Genius game core.
- A Galois LFSR produces symbols (button/colour indices). Each append request adds one symbol to an on-chip sequence memory.
- The sequence can be replayed from index 0 for LED display and player-input checking.
- The game controller owns seeding, append, clear and playback. Free-running mode lets player timing stir the LFSR for entropy.

Parameters:
LFSR_WIDTH, 16, LFSR state width (>= SYM_WIDTH, >= 2)
SYM_WIDTH, 2, symbol width (2 -> 4 colours)
DEPTH, 32, maximum stored sequence length
TAPS, 16'hB400, Galois feedback mask (x^16+x^14+x^13+x^11+1)
RESET_SEED, 1, LFSR value after reset (must be nonzero)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
seed_we  in  1  load seed into LFSR
seed  in  LFSR_WIDTH  seed value
free_run  in  1  step LFSR every cycle while high
append  in  1  generate and store one symbol
clear  in  1  empty sequence, abort playback
rd_start  in  1  begin playback at index 0
rd_next  in  1  advance playback pointer
rd_data  out  SYM_WIDTH  current playback symbol (registered)
rd_valid  out  1  rd_data valid
rd_last  out  1  rd_valid and pointer at final entry
len  out  $clog2(DEPTH+1)  stored sequence length
full  out  1  len == DEPTH
overflow  out  1  one-cycle pulse: append rejected because full

Behaviour:
Reset (rst=1 at a clk edge):
- lfsr=RESET_SEED, len=0, full=0, rd_ptr=0, state=IDLE.
- rd_data=0, rd_valid=0, rd_last=0, overflow=0.
- rst overrides every other input. Reset mid-playback returns to IDLE with the sequence emptied.

LFSR step (Galois):
- next = (lfsr >> 1) ^ (lfsr[0] ? TAPS : 0).
- At most one step per cycle.
- Steps when an accepted append occurs, or when free_run=1. Both together give one step, not two.

Seed load:
- seed_we=1: lfsr <= seed. If seed==0, lfsr <= 1 instead (avoids lock-up).
- seed_we overrides any step that cycle. Sequence memory and len are unchanged.

Input priority (one edge): rst > clear > seed_we > append/step.

Append:
- Accepted only in IDLE with len<DEPTH.
- Stores mem[len] <= lfsr[SYM_WIDTH-1:0] (the pre-step value), then len <= len+1 and the LFSR steps.
- Visible on len and full the next cycle.
- append while full: memory, len and lfsr are unchanged (a free_run step still occurs), and overflow pulses high for 1 cycle.
- append in PLAY: ignored, no overflow pulse.
- append in the same cycle as seed_we: the seed wins and the append is dropped.

Clear:
- len <= 0, full <= 0, state <= IDLE, rd_valid <= 0, rd_last <= 0.
- lfsr is untouched (free_run stepping still applies).

Playback FSM, states IDLE and PLAY:
- IDLE + rd_start with len>0: rd_ptr <= 0, go to PLAY. rd_valid=1 and rd_data=mem[0] on the following cycle (latency 1).
- IDLE + rd_start with len==0: ignored.
- PLAY + rd_next with rd_ptr<len-1: rd_ptr++, rd_data updates next cycle with rd_valid held high.
- PLAY + rd_next with rd_ptr==len-1: go to IDLE, rd_valid and rd_last go low next cycle.
- rd_start in PLAY restarts at index 0.
- rd_next in IDLE: ignored.
- rd_last = rd_valid && rd_ptr==len-1 (registered, aligned with rd_data).
- Sequence is frozen during PLAY, so len cannot change under the pointer.
- full is combinational from len or registered, always exactly len==DEPTH.

Test Plan:
1. rst; seed_we with seed=16'h0001; append on 3 consecutive cycles -> len=3, stored symbols 1,0,0, lfsr=16'h2D00.
2. After scenario 1: rd_start, then rd_next each cycle -> rd_data 1,0,0 on consecutive cycles starting 1 cycle after rd_start. rd_last high only with the third symbol, and rd_valid low the cycle after the final rd_next.
3. seed_we with seed=0 -> lfsr=16'h0001. Then free_run=1 for 2 cycles with no append -> lfsr=16'h5A00, len unchanged.
4. DEPTH=4: append 5 times -> len=4, full=1, overflow pulses exactly once on the 5th append, mem[0..3] unchanged.
5. During PLAY at rd_ptr=1: assert append -> ignored. Assert clear -> next cycle rd_valid=0, len=0, state IDLE. rd_start with len=0 -> rd_valid stays 0.
6. rst asserted mid-playback together with append and seed_we -> all outputs at reset values next cycle, lfsr=RESET_SEED.
